// File: rtl/mul_arbiter.sv
// mul_arbiter: round-robin sharing of one pipelined 32x32 multiplier between NREQ requesters,
// with a tag FIFO routing each product back to its issuer. Perf counters gated by MUL_ARB_PERF_EN.
module mul_arbiter #(
    parameter int unsigned NREQ         = 2,
    parameter int unsigned MAX_INFLIGHT = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NREQ-1:0]     req_val,
    input  logic [32*NREQ-1:0]  req_a,
    input  logic [32*NREQ-1:0]  req_b,
    output logic [NREQ-1:0]     req_rdy,
    output logic [NREQ-1:0]     resp_val,
    output logic [63:0]         resp_p,
    output logic [31:0]         mul_a,
    output logic [31:0]         mul_b,
    output logic                mul_val_op,
    input  logic                mul_oprand_rdy,
    input  logic                mul_commit,
    input  logic [63:0]         mul_longP,
    output logic                err_underflow,
    output logic [31:0]         perf_issue,
    output logic [31:0]         perf_commit
);
    localparam int unsigned IW = $clog2(NREQ);
    localparam int unsigned PW = $clog2(MAX_INFLIGHT);
    localparam int unsigned CW = $clog2(MAX_INFLIGHT + 1);

    logic [IW-1:0] rr;
    logic [IW-1:0] gnt;
    logic [IW-1:0] cand;
    logic          found;
    logic [31:0]   op_a;
    logic [31:0]   op_b;
    logic          issue;

    logic [IW-1:0] tag_mem [MAX_INFLIGHT];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          fifo_full;
    logic          fifo_empty;
    logic          push;
    logic          pop;
    logic [IW-1:0] head;
    logic [NREQ-1:0] head_oh;

    // Scan requesters in cyclic order starting at rr; the first valid one wins.
    always_comb begin
        gnt   = rr;
        cand  = rr;
        found = 1'b0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            cand = IW'((32'(rr) + k) % NREQ);
            if (!found && req_val[cand]) begin
                found = 1'b1;
                gnt   = cand;
            end
        end
    end

    always_comb begin
        op_a = '0;
        op_b = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (gnt == IW'(k)) begin
                op_a = req_a[32*k +: 32];
                op_b = req_b[32*k +: 32];
            end
        end
    end

    assign fifo_full  = (count == CW'(MAX_INFLIGHT));
    assign fifo_empty = (count == '0);

    // Full is taken from the registered count, so a same-cycle commit never reopens issue.
    assign mul_val_op = found && !fifo_full;
    assign mul_a      = mul_val_op ? op_a : '0;
    assign mul_b      = mul_val_op ? op_b : '0;
    assign issue      = mul_val_op && mul_oprand_rdy;

    always_comb begin
        req_rdy = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            req_rdy[k] = issue && (gnt == IW'(k));
        end
    end

    assign push = issue;
    assign pop  = mul_commit && !fifo_empty;
    assign head = tag_mem[rd_ptr];

    always_comb begin
        head_oh = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            head_oh[k] = (head == IW'(k));
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rr <= '0;
        end else if (issue) begin
            rr <= (gnt == IW'(NREQ - 1)) ? '0 : gnt + IW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            tag_mem[wr_ptr] <= gnt;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            resp_val      <= '0;
            resp_p        <= '0;
            err_underflow <= 1'b0;
        end else begin
            resp_val <= pop ? head_oh : '0;
            if (pop) begin
                resp_p <= mul_longP;
            end
            if (mul_commit && fifo_empty) begin
                err_underflow <= 1'b1;
            end
        end
    end

`ifdef MUL_ARB_PERF_EN
    logic [31:0] issue_cnt;
    logic [31:0] commit_cnt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            issue_cnt  <= '0;
            commit_cnt <= '0;
        end else begin
            if (issue) begin
                issue_cnt <= issue_cnt + 32'd1;
            end
            if (pop) begin
                commit_cnt <= commit_cnt + 32'd1;
            end
        end
    end

    assign perf_issue  = issue_cnt;
    assign perf_commit = commit_cnt;
`else
    assign perf_issue  = '0;
    assign perf_commit = '0;
`endif

endmodule

// File: tb/tb_mul_arbiter.sv
// Directed self-checking bench for mul_arbiter with a small latency-3 multiplier model.
module tb_mul_arbiter;
    localparam int NREQ = 2;
    localparam int MAXF = 4;
    localparam int LAT  = 3;
`ifdef MUL_ARB_PERF_EN
    localparam int PERF_EXP = 10;
`else
    localparam int PERF_EXP = 0;
`endif

    logic                clk = 1'b0;
    logic                reset;
    logic [NREQ-1:0]     req_val;
    logic [32*NREQ-1:0]  req_a;
    logic [32*NREQ-1:0]  req_b;
    logic [NREQ-1:0]     req_rdy;
    logic [NREQ-1:0]     resp_val;
    logic [63:0]         resp_p;
    logic [31:0]         mul_a;
    logic [31:0]         mul_b;
    logic                mul_val_op;
    logic                mul_oprand_rdy;
    logic                mul_commit;
    logic [63:0]         mul_longP;
    logic                err_underflow;
    logic [31:0]         perf_issue;
    logic [31:0]         perf_commit;

    always #5 clk = ~clk;

    mul_arbiter #(.NREQ(NREQ), .MAX_INFLIGHT(MAXF)) dut (
        .clk            (clk),
        .reset          (reset),
        .req_val        (req_val),
        .req_a          (req_a),
        .req_b          (req_b),
        .req_rdy        (req_rdy),
        .resp_val       (resp_val),
        .resp_p         (resp_p),
        .mul_a          (mul_a),
        .mul_b          (mul_b),
        .mul_val_op     (mul_val_op),
        .mul_oprand_rdy (mul_oprand_rdy),
        .mul_commit     (mul_commit),
        .mul_longP      (mul_longP),
        .err_underflow  (err_underflow),
        .perf_issue     (perf_issue),
        .perf_commit    (perf_commit)
    );

    typedef struct {
        logic [63:0] p;
        int          due;
    } op_t;

    op_t  pipe[$];
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    logic commit_en;
    logic force_commit;

    int rr_a0[3] = '{2, 4, 6};
    int rr_b0[3] = '{3, 5, 7};
    int rr_a1[3] = '{10, 12, 14};
    int rr_b1[3] = '{11, 13, 15};
    int rr_g[6]  = '{0, 1, 0, 1, 0, 1};
    int rr_p[6]  = '{6, 110, 20, 156, 42, 210};

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b);
        req_a[32*i +: 32] = a;
        req_b[32*i +: 32] = b;
    endtask

    // One clock: record any issue into the multiplier model, then drive commit for the new cycle.
    task automatic tick();
        #1;
        if (reset && mul_val_op && mul_oprand_rdy)
            pipe.push_back('{p: 64'(mul_a) * 64'(mul_b), due: cyc + LAT});
        @(posedge clk);
        cyc++;
        @(negedge clk);
        mul_commit = 1'b0;
        mul_longP  = '0;
        if (force_commit) begin
            mul_commit   = 1'b1;
            mul_longP    = 64'hDEAD;
            force_commit = 1'b0;
        end else if (commit_en && pipe.size() > 0 && pipe[0].due <= cyc) begin
            mul_commit = 1'b1;
            mul_longP  = pipe[0].p;
            void'(pipe.pop_front());
        end
    endtask

    task automatic do_reset();
        req_val        = '0;
        mul_oprand_rdy = 1'b1;
        commit_en      = 1'b1;
        force_commit   = 1'b0;
        mul_commit     = 1'b0;
        mul_longP      = '0;
        reset          = 1'b0;
        pipe.delete();
        tick();
        tick();
        reset = 1'b1;
        pipe.delete();
    endtask

    initial begin
        int n0;
        int n1;
        int na;
        reset = 1'b0;
        req_a = '0;
        req_b = '0;

        // Reset state and single requester
        do_reset();
        #1;
        check_val("rst_resp_val", resp_val, 0);
        check_val("rst_resp_p", resp_p, 0);
        check_val("rst_err", err_underflow, 0);
        check_val("rst_val_op", mul_val_op, 0);
        check_val("rst_req_rdy", req_rdy, 0);
        check_val("rst_perf_issue", perf_issue, 0);
        req_val = 2'b01;
        set_req(0, 7, 6);
        #1;
        check_val("t1_rdy", req_rdy, 2'b01);
        check_val("t1_mul_a", mul_a, 7);
        check_val("t1_mul_b", mul_b, 6);
        tick();
        req_val = '0;
        #1;
        check_val("t1_idle_mul_a", mul_a, 0);
        for (int k = 1; k <= 6; k++) begin
            #1;
            check_val("t1_resp_val", resp_val, (k == LAT + 1) ? 64'd1 : 64'd0);
            if (k == LAT + 1) check_val("t1_resp_p", resp_p, 42);
            tick();
        end

        // Round-robin fairness
        do_reset();
        n0 = 0;
        n1 = 0;
        for (int c = 0; c < 10; c++) begin
            req_val = {n1 < 3, n0 < 3};
            if (n0 < 3) set_req(0, rr_a0[n0], rr_b0[n0]);
            if (n1 < 3) set_req(1, rr_a1[n1], rr_b1[n1]);
            #1;
            if (c < 6) check_val("t2_gnt", req_rdy, 64'(1) << rr_g[c]);
            else       check_val("t2_idle_rdy", req_rdy, 0);
            if (c >= 4) begin
                check_val("t2_resp_val", resp_val, 64'(1) << rr_g[c-4]);
                check_val("t2_resp_p", resp_p, 64'(rr_p[c-4]));
            end else begin
                check_val("t2_no_resp", resp_val, 0);
            end
            if (c < 6) begin
                if (rr_g[c] == 0) n0++;
                else              n1++;
            end
            tick();
        end
        repeat (4) tick();

        // Full FIFO
        do_reset();
        commit_en = 1'b0;
        na = 0;
        req_val = 2'b01;
        for (int c = 0; c < 6; c++) begin
            set_req(0, 32'(na + 3), 4);
            #1;
            check_val("t3_val_op", mul_val_op, (c < 4) ? 64'd1 : 64'd0);
            check_val("t3_rdy", req_rdy, (c < 4) ? 64'd1 : 64'd0);
            if (c < 4) na++;
            if (c == 5) commit_en = 1'b1;
            tick();
        end
        set_req(0, 32'(na + 3), 4);
        #1;
        check_val("t3_commit_cycle_blocked", mul_val_op, 0);
        tick();
        #1;
        check_val("t3_reopen_val_op", mul_val_op, 1);
        check_val("t3_reopen_rdy", req_rdy, 2'b01);
        check_val("t3_resp_val", resp_val, 2'b01);
        check_val("t3_resp_p", resp_p, 12);
        tick();
        req_val = '0;
        repeat (10) tick();

        // Multiplier stall
        do_reset();
        req_val = 2'b01;
        set_req(0, 2, 2);
        #1;
        check_val("t4_pre", req_rdy, 2'b01);
        tick();
        req_val = 2'b11;
        set_req(0, 5, 5);
        set_req(1, 9, 9);
        mul_oprand_rdy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            check_val("t4_stall_rdy", req_rdy, 0);
            check_val("t4_stall_mul_a", mul_a, 9);
            tick();
        end
        mul_oprand_rdy = 1'b1;
        #1;
        check_val("t4_issue", req_rdy, 2'b10);
        check_val("t4_issue_mul_a", mul_a, 9);
        tick();
        req_val = 2'b01;
        #1;
        check_val("t4_next", req_rdy, 2'b01);
        check_val("t4_next_mul_a", mul_a, 5);
        tick();
        req_val = '0;
        repeat (8) tick();

        // Underflow, then reset with ops in flight
        do_reset();
        force_commit = 1'b1;
        tick();
        #1;
        check_val("t5_err_pre", err_underflow, 0);
        tick();
        for (int k = 0; k < 3; k++) begin
            #1;
            check_val("t5_err_sticky", err_underflow, 1);
            check_val("t5_no_resp", resp_val, 0);
            tick();
        end
        req_val = 2'b01;
        set_req(0, 3, 3);
        tick();
        set_req(0, 4, 4);
        tick();
        req_val = '0;
        reset = 1'b0;
        pipe.delete();
        tick();
        reset = 1'b1;
        pipe.delete();
        #1;
        check_val("t5_rst_err", err_underflow, 0);
        check_val("t5_rst_resp_val", resp_val, 0);
        check_val("t5_rst_resp_p", resp_p, 0);
        check_val("t5_rst_perf_issue", perf_issue, 0);
        check_val("t5_rst_perf_commit", perf_commit, 0);
        force_commit = 1'b1;
        tick();
        tick();
        #1;
        check_val("t5_count_zero", err_underflow, 1);
        req_val = 2'b11;
        set_req(0, 1, 1);
        set_req(1, 2, 2);
        #1;
        check_val("t5_first_gnt", req_rdy, 2'b01);
        tick();
        req_val = '0;
        repeat (8) tick();

        // Perf counters
        do_reset();
        req_val = 2'b01;
        for (int i = 0; i < 10; i++) begin
            set_req(0, 32'(i + 1), 2);
            tick();
        end
        req_val = '0;
        repeat (8) tick();
        #1;
        check_val("t6_perf_issue", perf_issue, 64'(PERF_EXP));
        check_val("t6_perf_commit", perf_commit, 64'(PERF_EXP));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
